// File: rtl/flappy_pkg.sv
// Shared types and geometry for the flappy display path.
// The VGA overlay logic uses the same widths as the bird motion controller.
package flappy_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        PLAY = 2'b01,
        DEAD = 2'b10
    } game_state_t;

    localparam int VIDEO_WIDTH  = 640;
    localparam int VIDEO_HEIGHT = 480;
    localparam int BIRD_H       = 50;

    // Default widths of the bird_y and velocity registers.
    localparam int Y_W_DEF = 9;
    localparam int V_W_DEF = 6;

endpackage

// File: rtl/sync_rise_det.sv
// Brings an asynchronous level into the clk domain with a two-flop synchroniser.
// Produces a registered one-cycle pulse on each rising edge of the level.
module sync_rise_det (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic rise
);

    logic sync_1;
    logic sync_2;
    logic sync_2_d;

    // NOTE: every flop uses a non-blocking assignment, so all of them sample
    // the values they held before this edge and the chain shifts one stage per clock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_1   <= 1'b0;
            sync_2   <= 1'b0;
            sync_2_d <= 1'b0;
            rise     <= 1'b0;
        end else begin
            sync_1   <= din;
            sync_2   <= sync_1;
            sync_2_d <= sync_2;
            rise     <= sync_2 & ~sync_2_d;
        end
    end

endmodule

// File: rtl/bird_motion_controller.sv
// Per-frame game sequencer that owns the bird sprite's vertical position.
// On each frame tick it applies gravity and flaps, clamps at the ceiling, detects the floor and runs the game FSM.
module bird_motion_controller
    import flappy_pkg::*;
#(
    parameter int Y_W      = Y_W_DEF,
    parameter int V_W      = V_W_DEF,
    parameter int Y_INIT   = 200,
    parameter int Y_MAX    = 430,
    parameter int GRAVITY  = 1,
    parameter int FLAP_VEL = -8,
    parameter int VEL_MAX  = 10
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           screen_end,
    input  logic           flap,
    input  logic           start,
    output logic [Y_W-1:0] bird_y,
    output logic [1:0]     game_state,
    output logic           frame_update,
    output logic           dead
);

    localparam logic [Y_W-1:0]        Y_INIT_V = Y_W'(Y_INIT);
    localparam logic [Y_W-1:0]        Y_MAX_V  = Y_W'(Y_MAX);
    localparam logic signed [Y_W+1:0] Y_MAX_S  = (Y_W+2)'(Y_MAX);
    localparam logic signed [V_W-1:0] FLAP_V   = V_W'(FLAP_VEL);
    localparam logic signed [V_W-1:0] VMAX_V   = V_W'(VEL_MAX);
    localparam logic signed [V_W:0]   VMAX_X   = (V_W+1)'(VEL_MAX);
    localparam logic signed [V_W:0]   GRAV_X   = (V_W+1)'(GRAVITY);

    logic tick;
    logic flap_rise;
    logic start_rise;

    sync_rise_det u_sync_tick  (.clk(clk), .reset(reset), .din(screen_end), .rise(tick));
    sync_rise_det u_sync_flap  (.clk(clk), .reset(reset), .din(flap),       .rise(flap_rise));
    sync_rise_det u_sync_start (.clk(clk), .reset(reset), .din(start),      .rise(start_rise));

    game_state_t           state_q, state_d;
    logic [Y_W-1:0]        y_q, y_d;
    logic signed [V_W-1:0] vel_q, vel_d;
    logic                  flap_pend, start_pend;
    logic                  flap_eff, start_eff;
    logic signed [V_W:0]   vel_inc;
    logic signed [V_W-1:0] vel_n;
    logic signed [Y_W+1:0] y_n;

    // A press arriving in the same cycle as the tick still counts for that tick.
    assign flap_eff  = flap_pend | flap_rise;
    assign start_eff = start_pend | start_rise;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flap_pend  <= 1'b0;
            start_pend <= 1'b0;
        end else begin
            if (state_q != PLAY || tick) begin
                flap_pend <= 1'b0;
            end else if (flap_rise) begin
                flap_pend <= 1'b1;
            end
            if (tick) begin
                start_pend <= 1'b0;
            end else if (start_rise) begin
                start_pend <= 1'b1;
            end
        end
    end

    // NOTE: every variable driven here gets a default before any branch,
    // so no path can leave a value unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        vel_d   = vel_q;
        vel_inc = {vel_q[V_W-1], vel_q} + GRAV_X;
        vel_n   = (vel_inc > VMAX_X) ? VMAX_V : vel_inc[V_W-1:0];
        if (flap_eff) begin
            vel_n = FLAP_V;
        end
        y_n = signed'({2'b00, y_q}) + (Y_W+2)'(vel_n);

        if (tick) begin
            unique case (state_q)
                IDLE: begin
                    y_d   = Y_INIT_V;
                    vel_d = '0;
                    if (start_eff) begin
                        state_d = PLAY;
                    end
                end
                PLAY: begin
                    if (y_n < 0) begin
                        y_d   = '0;
                        vel_d = '0;
                    end else if (y_n >= Y_MAX_S) begin
                        y_d     = Y_MAX_V;
                        vel_d   = '0;
                        state_d = DEAD;
                    end else begin
                        y_d   = y_n[Y_W-1:0];
                        vel_d = vel_n;
                    end
                end
                DEAD: begin
                    if (start_eff) begin
                        state_d = IDLE;
                        y_d     = Y_INIT_V;
                        vel_d   = '0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            y_q          <= Y_INIT_V;
            vel_q        <= '0;
            frame_update <= 1'b0;
        end else begin
            state_q      <= state_d;
            y_q          <= y_d;
            vel_q        <= vel_d;
            frame_update <= tick;
        end
    end

    assign bird_y     = y_q;
    assign game_state = state_q;
    assign dead       = (state_q == DEAD);

endmodule

// File: tb/tb_bird_motion_controller.sv
// Scoreboard bench for bird_motion_controller: tasks drive frames and presses and queue expected frames.
// A negedge monitor pops the queue on every frame_update; the expected frames come from a frame-level game model.
module tb_bird_motion_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic       screen_end;
    logic       flap;
    logic       start;
    logic [8:0] bird_y;
    logic [1:0] game_state;
    logic       frame_update;
    logic       dead;

    always #5 clk = ~clk;

    bird_motion_controller dut (
        .clk          (clk),
        .reset        (reset),
        .screen_end   (screen_end),
        .flap         (flap),
        .start        (start),
        .bird_y       (bird_y),
        .game_state   (game_state),
        .frame_update (frame_update),
        .dead         (dead)
    );

    typedef struct {
        int y;
        int st;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;
    bit   mon_en   = 1'b0;
    int   last_y   = 200;
    int   last_st  = 0;

    // Game model, one step per frame: 0 IDLE, 1 PLAY, 2 DEAD.
    int m_y, m_vel, m_st;
    bit m_fp, m_sp;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_y = 200; m_vel = 0; m_st = 0; m_fp = 0; m_sp = 0;
        q.delete();
        last_y = 200; last_st = 0;
    endtask

    task automatic model_tick();
        int vn, yn;
        case (m_st)
            0: begin
                m_y = 200; m_vel = 0;
                if (m_sp) m_st = 1;
            end
            1: begin
                vn = m_fp ? -8 : ((m_vel + 1 > 10) ? 10 : m_vel + 1);
                yn = m_y + vn;
                if (yn < 0) begin
                    m_y = 0; m_vel = 0;
                end else if (yn >= 430) begin
                    m_y = 430; m_vel = 0; m_st = 2;
                end else begin
                    m_y = yn; m_vel = vn;
                end
            end
            default: begin
                if (m_sp) begin
                    m_st = 0; m_y = 200; m_vel = 0;
                end
            end
        endcase
        m_fp = 0;
        m_sp = 0;
        q.push_back('{m_y, m_st});
    endtask

    task automatic set_flap(input bit v);
        if (v && !flap) m_fp = 1;
        flap = v;
    endtask

    task automatic set_start(input bit v);
        if (v && !start) m_sp = 1;
        start = v;
    endtask

    always @(negedge clk) begin
        if (mon_en && !reset) begin
            if (frame_update) begin
                check("frame_expected", (q.size() > 0) ? 1 : 0, 1);
                if (q.size() > 0) begin
                    mon_e = q.pop_front();
                    check("bird_y", int'(bird_y), mon_e.y);
                    check("game_state", int'(game_state), mon_e.st);
                    last_y  = mon_e.y;
                    last_st = mon_e.st;
                end
            end else begin
                check("bird_y_stable", int'(bird_y), last_y);
                check("state_stable", int'(game_state), last_st);
            end
            check("dead", int'(dead), (last_st == 2) ? 1 : 0);
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #3;
        reset = 1'b1;
        screen_end = 1'b0; flap = 1'b0; start = 1'b0;
        model_reset();
        #1;
        check("rst_bird_y", int'(bird_y), 200);
        check("rst_state", int'(game_state), 0);
        check("rst_frame_update", int'(frame_update), 0);
        check("rst_dead", int'(dead), 0);
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_bird_y", int'(bird_y), 200);
        check("post_rst_frame_update", int'(frame_update), 0);
    endtask

    task automatic do_tick(input bit with_flap);
        int lat;
        lat = 0;
        @(posedge clk);
        #1;
        screen_end = 1'b1;
        if (with_flap) set_flap(1'b1);
        model_tick();
        for (int k = 1; k <= 8 && lat == 0; k++) begin
            @(posedge clk);
            #1;
            if (frame_update) lat = k;
        end
        check("tick_latency", lat, 4);
        screen_end = 1'b0;
        if (with_flap) set_flap(1'b0);
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic press(input bit is_start);
        @(posedge clk);
        #1;
        if (is_start) set_start(1'b1); else set_flap(1'b1);
        repeat (2) @(posedge clk);
        #1;
        if (is_start) set_start(1'b0); else set_flap(1'b0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; screen_end = 1'b0; flap = 1'b0; start = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        mon_en = 1'b1;
        do_reset();

        // Enter PLAY, then free fall 201, 203, 206.
        press(1'b1);
        do_tick(1'b0);
        repeat (3) do_tick(1'b0);

        // Three flaps between ticks collapse into one.
        repeat (3) press(1'b0);
        do_tick(1'b0);
        do_tick(1'b0);

        // Flaps coincident with ticks climb into the ceiling clamp.
        repeat (30) do_tick(1'b1);

        // Fall to the floor, then flaps and ticks in DEAD change nothing.
        repeat (50) do_tick(1'b0);
        press(1'b0);
        repeat (3) do_tick(1'b0);

        // Start held high across five ticks gives one restart to IDLE.
        @(posedge clk);
        #1;
        set_start(1'b1);
        repeat (4) @(posedge clk);
        repeat (5) do_tick(1'b0);
        set_start(1'b0);
        repeat (2) do_tick(1'b0);
        press(1'b1);
        do_tick(1'b0);
        repeat (5) do_tick(1'b0);

        // Reset in the middle of a frame aborts the pending tick.
        @(posedge clk);
        #1;
        screen_end = 1'b1;
        repeat (2) @(posedge clk);
        do_reset();
        do_tick(1'b0);

        for (int f = 0; f < 250; f++) begin
            if ($urandom_range(0, 2) == 0) press(1'b0);
            if ($urandom_range(0, 3) == 0) press(1'b0);
            if ($urandom_range(0, 9) == 0) press(1'b1);
            do_tick($urandom_range(0, 4) == 0);
        end

        repeat (10) @(posedge clk);
        check("queue_empty", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
